// File: rtl/spike_count_classifier_if.sv
// Handshake/bus bundle between the spike-count classifier and its
// surrounding logic: window control, spike sample stream and the result
// valid/ack port.
interface spike_count_classifier_if #(
  parameter int N     = 8,
  parameter int CNT_W = 8,
  parameter int WIN_W = 8,
  parameter int CLS_W = 3
);
  logic             start;
  logic [WIN_W-1:0] window_len;
  logic [N-1:0]     spikes_in;
  logic             spikes_valid;
  logic             class_ack;
  logic             busy;
  logic             class_valid;
  logic [CLS_W-1:0] class_out;
  logic [CNT_W-1:0] max_count;
  logic             tie;

  modport master (
    output start, window_len, spikes_in, spikes_valid, class_ack,
    input  busy, class_valid, class_out, max_count, tie
  );

  modport slave (
    input  start, window_len, spikes_in, spikes_valid, class_ack,
    output busy, class_valid, class_out, max_count, tie
  );
endinterface

// File: rtl/spike_count_classifier.sv
// Spike-count classifier: accumulates saturating per-neuron spike counts over
// a programmable number of valid samples, then scans the counters one neuron
// per clock to find the argmax (lowest index wins ties) and offers the class
// index on a valid/ack handshake.
//
// Optional build macro SPIKE_CLS_COUNTS_EN exposes the live counter values on
// counts_out (neuron i at bits [i*CNT_W +: CNT_W]).
//
// state | meaning
// IDLE  | waiting for start; counters and last result retained
// ACCUM | counting spikes on samples qualified by spikes_valid
// SCAN  | one neuron compared per clock, index 0..N-1
// DONE  | result presented with class_valid, waiting for class_ack
module spike_count_classifier #(
  parameter int N     = 8,
  parameter int CNT_W = 8,
  parameter int WIN_W = 8,
  parameter int CLS_W = 3
) (
  input logic clk,
  input logic reset,
  spike_count_classifier_if.slave bus
`ifdef SPIKE_CLS_COUNTS_EN
  ,
  output logic [N*CNT_W-1:0] counts_out
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    SCAN  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt [N];
  logic [WIN_W-1:0] remaining;
  logic [CLS_W-1:0] idx;
  logic [CNT_W-1:0] cur;
  logic             take;
  logic             last_take;
  logic             scan_last;
  logic             busy_d;
  logic             valid_d;

  // Samples remaining is a down-counter; the window closes on the sample
  // that brings it from 1 to 0.
  assign take      = (state == ACCUM) && bus.spikes_valid;
  assign last_take = take && (remaining == WIN_W'(1));
  assign scan_last = (idx == CLS_W'(N - 1));
  assign cur       = cnt[idx];

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state decode
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start)   state_next = ACCUM;
      ACCUM:   if (last_take)   state_next = SCAN;
      SCAN:    if (scan_last)   state_next = DONE;
      DONE:    if (bus.class_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode, taken from the next state so the registered flags line up
  // with the state they describe
  always_comb begin
    busy_d  = (state_next != IDLE);
    valid_d = (state_next == DONE);
  end

  // Registered status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.busy        <= 1'b0;
      bus.class_valid <= 1'b0;
    end else begin
      bus.busy        <= busy_d;
      bus.class_valid <= valid_d;
    end
  end

  // Per-neuron saturating spike counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else if ((state == IDLE) && bus.start) begin
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else if (take) begin
      for (int i = 0; i < N; i++)
        if (bus.spikes_in[i] && (cnt[i] != {CNT_W{1'b1}}))
          cnt[i] <= cnt[i] + CNT_W'(1);
    end
  end

  // Window down-counter; a zero window length is stretched to one sample
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      remaining <= '0;
    end else if ((state == IDLE) && bus.start) begin
      remaining <= (bus.window_len == '0) ? WIN_W'(1) : bus.window_len;
    end else if (take) begin
      remaining <= remaining - WIN_W'(1);
    end
  end

  // Sequential argmax scan; results stay held until the next scan
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx           <= '0;
      bus.class_out <= '0;
      bus.max_count <= '0;
      bus.tie       <= 1'b0;
    end else if (state == SCAN) begin
      idx <= scan_last ? '0 : idx + CLS_W'(1);
      if (idx == '0) begin
        bus.max_count <= cur;
        bus.class_out <= '0;
        bus.tie       <= 1'b0;
      end else if (cur > bus.max_count) begin
        bus.max_count <= cur;
        bus.class_out <= idx;
        bus.tie       <= 1'b0;
      end else if (cur == bus.max_count) begin
        bus.tie <= 1'b1;
      end
    end
  end

`ifdef SPIKE_CLS_COUNTS_EN
  // Counters only move in ACCUM, so this view is frozen through SCAN and DONE
  always_comb begin
    counts_out = '0;
    for (int i = 0; i < N; i++) counts_out[i*CNT_W +: CNT_W] = cnt[i];
  end
`endif

endmodule

// File: tb/tb_spike_count_classifier.sv
// Directed bench for spike_count_classifier with a window-level reference
// model and a per-cycle compare process.
module tb_spike_count_classifier;
  localparam int N     = 8;
  localparam int CNT_W = 8;
  localparam int WIN_W = 8;
  localparam int CLS_W = 3;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  spike_count_classifier_if #(.N(N), .CNT_W(CNT_W), .WIN_W(WIN_W), .CLS_W(CLS_W)) bus ();

`ifdef SPIKE_CLS_COUNTS_EN
  logic [N*CNT_W-1:0] counts_out;
`endif

  spike_count_classifier #(.N(N), .CNT_W(CNT_W), .WIN_W(WIN_W), .CLS_W(CLS_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef SPIKE_CLS_COUNTS_EN
    ,
    .counts_out (counts_out)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 idle, 1 accumulating, 2 result pending, 3 done
  int m_phase, m_remaining, m_countdown;
  int m_counts [N];
  int m_class, m_max, m_tie, p_class, p_max, p_tie;
  int m_busy, m_valid, m_known;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase = 0; m_remaining = 0; m_countdown = 0;
      for (int i = 0; i < N; i++) m_counts[i] = 0;
      m_class = 0; m_max = 0; m_tie = 0;
      m_busy = 0; m_valid = 0; m_known = 1;
    end else begin
      case (m_phase)
        0: if (bus.start) begin
             for (int i = 0; i < N; i++) m_counts[i] = 0;
             m_remaining = (bus.window_len == 0) ? 1 : int'(bus.window_len);
             m_phase = 1;
           end
        1: if (bus.spikes_valid) begin
             for (int i = 0; i < N; i++)
               if (bus.spikes_in[i] && m_counts[i] < CMAX) m_counts[i]++;
             m_remaining--;
             if (m_remaining == 0) begin
               int ties;
               p_max = -1; p_class = 0; ties = 0;
               for (int i = 0; i < N; i++)
                 if (m_counts[i] > p_max) begin p_max = m_counts[i]; p_class = i; end
               for (int i = 0; i < N; i++) if (m_counts[i] == p_max) ties++;
               p_tie = (ties > 1);
               m_phase = 2; m_countdown = N; m_known = 0;
             end
           end
        2: begin
             m_countdown--;
             if (m_countdown == 0) begin
               m_phase = 3; m_valid = 1; m_known = 1;
               m_class = p_class; m_max = p_max; m_tie = p_tie;
             end
           end
        default: if (bus.class_ack) begin m_phase = 0; m_valid = 0; end
      endcase
      m_busy = (m_phase != 0);
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    chk("busy", bus.busy, m_busy);
    chk("class_valid", bus.class_valid, m_valid);
    if (m_known) begin
      chk("class_out", bus.class_out, m_class);
      chk("max_count", bus.max_count, m_max);
      chk("tie", bus.tie, m_tie);
    end
`ifdef SPIKE_CLS_COUNTS_EN
    for (int i = 0; i < N; i++)
      chk("counts_out", counts_out[i*CNT_W +: CNT_W], m_counts[i]);
`endif
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic sample(input logic [N-1:0] v, input logic vld);
    bus.spikes_in = v;
    bus.spikes_valid = vld;
    cyc();
    bus.spikes_in = '0;
    bus.spikes_valid = 1'b0;
  endtask

  task automatic do_start(input int wl);
    bus.start = 1'b1;
    bus.window_len = WIN_W'(wl);
    cyc();
    bus.start = 1'b0;
  endtask

  task automatic wait_valid(input string name, output int n);
    n = 0;
    while (!bus.class_valid && n < 400) begin
      cyc();
      n++;
    end
    chk(name, bus.class_valid, 1);
  endtask

  task automatic ack();
    bus.class_ack = 1'b1;
    cyc();
    bus.class_ack = 1'b0;
    chk("ack_valid_drop", bus.class_valid, 0);
  endtask

  task automatic expect_result(input string name, input int c, input int m, input int t);
    chk({name, "_class"}, bus.class_out, c);
    chk({name, "_max"}, bus.max_count, m);
    chk({name, "_tie"}, bus.tie, t);
  endtask

  task automatic expect_zero_now(input string name);
    chk({name, "_busy"}, bus.busy, 0);
    chk({name, "_valid"}, bus.class_valid, 0);
    expect_result(name, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1;
    bus.start = 1'b0; bus.window_len = '0; bus.spikes_in = '0;
    bus.spikes_valid = 1'b0; bus.class_ack = 1'b0;
    repeat (3) cyc();
    reset = 1'b0;
    expect_zero_now("reset");

    // Samples and ack while idle must be ignored
    sample(8'hFF, 1'b1);
    ack();

    // Basic argmax with tie, latency N edges
    do_start(4);
    repeat (4) sample(8'b0000_0101, 1'b1);
    n = 0;
    while (!bus.class_valid && n < 50) begin cyc(); n++; end
    chk("t1_latency", n, 8);
    expect_result("t1", 0, 4, 1);
    chk("t1_model_cnt0", m_counts[0], 4);
    chk("t1_model_cnt2", m_counts[2], 4);
    chk("t1_model_cnt1", m_counts[1], 0);
    ack();

    // Clear winner with gaps; start pulses inside ACCUM ignored
    do_start(3);
    sample(8'h80, 1'b1);
    sample(8'hFF, 1'b0);
    bus.start = 1'b1; sample(8'h80, 1'b1); bus.start = 1'b0;
    sample(8'hFF, 1'b0);
    sample(8'hFF, 1'b0);
    sample(8'h01, 1'b1);
    wait_valid("t2_valid", n);
    expect_result("t2", 7, 2, 0);
    chk("t2_model_max", m_max, 2);

    // Hold in DONE with start pulses
    for (int i = 0; i < 20; i++) begin
      bus.start = (i % 3 == 0);
      bus.window_len = 8'd1;
      cyc();
    end
    bus.start = 1'b0;
    chk("hold_valid", bus.class_valid, 1);
    expect_result("hold", 7, 2, 0);
    ack();
    do_start(2);
    chk("restart_busy", bus.busy, 1);
    sample(8'h03, 1'b1);
    sample(8'h02, 1'b1);
    wait_valid("t3_valid", n);
    expect_result("t3", 1, 2, 0);
    ack();

    // Full-length window on one neuron
    do_start(255);
    repeat (255) sample(8'h01, 1'b1);
    wait_valid("sat_valid", n);
    expect_result("sat", 0, 255, 0);
    ack();

    // Zero window length acts as one sample
    do_start(0);
    sample(8'h00, 1'b1);
    n = 0;
    while (!bus.class_valid && n < 50) begin cyc(); n++; end
    chk("zero_latency", n, 8);
    expect_result("zero", 0, 0, 1);
    ack();

    // Reset during ACCUM
    do_start(5);
    sample(8'h0F, 1'b1);
    sample(8'h0F, 1'b1);
    reset = 1'b1;
    #1;
    expect_zero_now("rst_accum");
    cyc();
    reset = 1'b0;
    repeat (15) cyc();
    chk("rst_accum_novalid", bus.class_valid, 0);

    // Reset during SCAN
    do_start(1);
    sample(8'hFF, 1'b1);
    repeat (3) cyc();
    reset = 1'b1;
    #1;
    expect_zero_now("rst_scan");
    cyc();
    reset = 1'b0;
    repeat (15) cyc();
    chk("rst_scan_novalid", bus.class_valid, 0);

    // Recovery after reset
    do_start(2);
    sample(8'h10, 1'b1);
    sample(8'h10, 1'b1);
    wait_valid("t4_valid", n);
    expect_result("t4", 4, 2, 0);
    ack();
    repeat (3) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spike_count_classifier.md
Name: spike_count_classifier

Overview:
- Downstream consumer of the three-layer spiking network.
- Accumulates per-neuron output spike counts over a programmable number of valid network samples, qualified by the network's output_data_ready.
- Then scans the counters sequentially to pick the winning neuron (argmax) and presents the class index with a valid/ack handshake.

Parameters:
- N, 8, number of output neurons (spike vector width).
- CNT_W, 8, per-neuron spike counter width (saturating).
- WIN_W, 8, width of the window-length (sample count) field.
- CLS_W, 3, class index width; must satisfy 2**CLS_W >= N.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  pulse; begins a new classification window (honoured only in IDLE).
- window_len  input  WIN_W  number of valid samples to accumulate; latched on accepted start.
- spikes_in  input  N  output spike vector from the network.
- spikes_valid  input  1  sample qualifier; driven by the network's output_data_ready.
- class_ack  input  1  consumer acknowledges the result.
- busy  output  1  high in ACCUM, SCAN and DONE.
- class_valid  output  1  result valid (DONE state).
- class_out  output  CLS_W  winning neuron index.
- max_count  output  CNT_W  spike count of the winner.
- tie  output  1  another neuron equals the winning count.

Behaviour:
- Reset values: all outputs 0. All counters, sample counter and scan index cleared. FSM = IDLE. Reset mid-operation aborts immediately with no result.
- FSM states: IDLE, ACCUM, SCAN, DONE. All outputs are registered.
- IDLE:
  - start=1 clears all N counters and the sample counter, latches window_len, and moves to ACCUM.
  - A latched window_len of 0 is treated as 1.
  - spikes_valid is ignored in IDLE.
- ACCUM, on each edge with spikes_valid=1:
  - counter[i] += spikes_in[i]; saturates at 2**CNT_W-1 (no wrap).
  - Sample counter increments.
  - The edge that accepts sample number window_len moves to SCAN; that sample is counted.
  - Cycles with spikes_valid=0 change nothing.
  - start is ignored.
- SCAN:
  - Processes one neuron per edge, index 0..N-1.
  - Index 0 loads best=count[0], class=0, tie=0.
  - For each later index: count > best → new best, tie cleared. count == best → tie set, class unchanged (lowest index wins). count < best → nothing changes.
  - After index N-1 is processed, moves to DONE.
- Latency: class_valid rises exactly N edges after the edge that accepted the last sample.
- DONE:
  - class_valid=1; class_out, max_count and tie are held stable.
  - class_ack=1 sampled on an edge → IDLE, and class_valid falls on that edge.
  - start is ignored in DONE. start in the cycle after returning to IDLE is accepted.
  - Counters are retained until the next accepted start.
- All-zero window: class_out=0, max_count=0, tie=1 (for N>1).
- class_ack outside DONE has no effect.
- busy = (state != IDLE).

Optional Feature:
- Macro SPIKE_CLS_COUNTS_EN.
- When defined: adds output port counts_out [N*CNT_W-1:0], the concatenated live counter values, with neuron i at bits [i*CNT_W +: CNT_W]. It is frozen from SCAN through DONE and reads 0 after reset.
- When not defined: the port does not exist, and counters are internal only. Core behaviour is identical.

Test Plan:
- Basic argmax:
  - Stimulus: reset, then start with window_len=4; four valid samples of spikes_in=8'b0000_0101, then 8'b0000_0100 ×0.
  - Response: counts[0]=4, counts[2]=4, others 0. class_out=0, max_count=4, tie=1. class_valid rises exactly 8 edges after the 4th sample.
- Clear winner with gaps:
  - Stimulus: window_len=3; samples 8'h80, 8'h80, 8'h01 with spikes_valid=0 idle cycles interleaved.
  - Response: class_out=7, max_count=2, tie=0. Idle cycles are not counted.
- Saturation:
  - Stimulus: CNT_W=8, window_len=255 then a second window of 255 without start… instead, window_len=255, spikes_in=8'h01 every sample.
  - Response: max_count=255, no wrap. Repeat with CNT_W=4 build → max_count=15.
- Handshake:
  - Stimulus: hold class_ack=0 for 20 cycles in DONE, pulse start meanwhile.
  - Response: class_valid and outputs stable, start ignored. Ack → class_valid=0 next edge. A following start is accepted.
- Edge cases:
  - Stimulus: window_len=0 with one sample 8'h00.
  - Response: window ends after 1 sample; class_out=0, max_count=0, tie=1.
- Reset mid-operation:
  - Stimulus: assert reset during ACCUM (after 2 samples) and again during SCAN.
  - Response: all outputs 0 and busy=0 immediately; no class_valid follows.
